// File: rtl/popcount_stream_acc.sv
// popcount_stream_acc
// Two-stage streaming popcount accumulator. Stage 1 counts the ones in each
// accepted beat. Stage 2 adds that count into a saturating frame accumulator.
// When the beat marked in_last reaches stage 2, the frame result is loaded
// onto the output registers and the accumulator is cleared.
//
// Build option: define POPCOUNT_APPROX_EN to use the approximate per-beat
// count. Bits are taken in groups of 4 from bit 0, and each full group is
// capped at 3. Any remaining bits are counted exactly. Without the macro,
// the count is exact.
//
// Handshake: a beat transfers on a rising edge where in_valid & in_ready.
// A result transfers where out_valid & out_ready. While a result is held
// (out_valid & ~out_ready) the whole pipeline freezes and in_ready is low.
// When a result transfers and a new result loads in the same cycle,
// out_valid stays high.
module popcount_stream_acc #(
    parameter int N     = 21,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    input  logic [ACC_W-1:0] thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             out_fire,
    output logic             out_sat
);

    localparam int PC_W = $clog2(N + 1);

    // Per-beat ones count. In approximate mode, each full group of 4 bits
    // contributes at most 3.
    function automatic logic [PC_W-1:0] beat_count(input logic [N-1:0] d);
        logic [PC_W-1:0] c;
        logic [2:0]      gs;
        c  = '0;
        gs = '0;
`ifdef POPCOUNT_APPROX_EN
        for (int g = 0; g < N / 4; g++) begin
            gs = '0;
            for (int b = 0; b < 4; b++) begin
                gs = gs + {2'b00, d[4*g+b]};
            end
            if (gs > 3'd3) begin
                gs = 3'd3;
            end
            c = c + PC_W'(gs);
        end
        for (int i = (N / 4) * 4; i < N; i++) begin
            c = c + PC_W'(d[i]);
        end
`else
        for (int i = 0; i < N; i++) begin
            c = c + PC_W'(d[i]);
        end
`endif
        return c;
    endfunction

    logic            stall;
    logic            accept;
    logic            load;
    logic            s1_valid;
    logic [PC_W-1:0] s1_pc;
    logic            s1_last;
    logic [ACC_W-1:0] acc;
    logic            sat_acc;
    logic [ACC_W:0]  sum_wide;
    logic            sum_ovf;
    logic [ACC_W-1:0] sum;
    logic            sat_f;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    assign load     = s1_valid & ~stall;

    // Saturating add of the stage-1 count into the running frame sum
    always_comb begin
        sum_wide = {1'b0, acc} + (ACC_W + 1)'(s1_pc);
        sum_ovf  = sum_wide[ACC_W];
        sum      = sum_ovf ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
        sat_f    = sat_acc | sum_ovf;
    end

    // Stage 1: capture the beat count. Hold while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_pc    <= '0;
            s1_last  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_pc   <= beat_count(in_data);
                s1_last <= in_last;
            end
        end
    end

    // Stage 2: accumulate. On the frame's last beat, load the output
    // registers and clear the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            sat_acc   <= 1'b0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_fire  <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            if (load) begin
                if (s1_last) begin
                    out_count <= sum;
                    out_fire  <= (sum >= thresh);
                    out_sat   <= sat_f;
                    acc       <= '0;
                    sat_acc   <= 1'b0;
                end else begin
                    acc       <= sum;
                    sat_acc   <= sat_f;
                end
            end
            if (load && s1_last) begin
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_popcount_stream_acc.sv
// Testbench for popcount_stream_acc (N=21, ACC_W=8).
// A frame-level reference model turns each accepted beat into a count and
// keeps a running total. At in_last it queues {sat, fire, count}. Every
// delivered result is popped from that queue and compared.
module tb_popcount_stream_acc;

    localparam int N     = 21;
    localparam int ACC_W = 8;
    localparam int MAXV  = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_data = '0;
    logic             in_last = 1'b0;
    logic [ACC_W-1:0] thresh = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_count;
    logic             out_fire;
    logic             out_sat;

    popcount_stream_acc #(.N(N), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .thresh    (thresh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_fire  (out_fire),
        .out_sat   (out_sat)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check / counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [ACC_W+1:0] exp_q[$];   // {sat, fire, count}
    int frame_total = 0;

    function automatic int ref_pc(input logic [N-1:0] d);
        int c;
        int g;
        c = 0;
`ifdef POPCOUNT_APPROX_EN
        for (int k = 0; k < N / 4; k++) begin
            g = 0;
            for (int b = 0; b < 4; b++) g += int'(d[4*k+b]);
            c += (g > 3) ? 3 : g;
        end
        for (int i = (N / 4) * 4; i < N; i++) c += int'(d[i]);
`else
        g = 0;
        c = $countones(d);
`endif
        return c;
    endfunction

    function automatic logic [N-1:0] rand_bits(input int k);
        logic [N-1:0] d;
        int pos;
        d = '0;
        while ($countones(d) < k) begin
            pos = $urandom_range(0, N - 1);
            d[pos] = 1'b1;
        end
        return d;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic             hold_prev = 1'b0;
    logic [ACC_W-1:0] prev_count;
    logic             prev_fire;
    logic             prev_sat;

    always @(negedge clk) begin
        int clamp;
        logic [ACC_W+1:0] e;
        if (!rst) begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_count", out_count, prev_count);
                check("hold_fire", out_fire, prev_fire);
                check("hold_sat", out_sat, prev_sat);
            end
            hold_prev  = out_valid && !out_ready;
            prev_count = out_count;
            prev_fire  = out_fire;
            prev_sat   = out_sat;
            if (in_valid && in_ready) begin
                frame_total += ref_pc(in_data);
                if (in_last) begin
                    clamp = (frame_total > MAXV) ? MAXV : frame_total;
                    exp_q.push_back({frame_total > MAXV, clamp >= int'(thresh), ACC_W'(clamp)});
                    frame_total = 0;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("count", out_count, e[ACC_W-1:0]);
                    check("fire", out_fire, e[ACC_W]);
                    check("sat", out_sat, e[ACC_W+1]);
                end
            end
        end
    end

    // ---------------- out_ready driver ----------------
    int ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
    always @(posedge clk) begin
        #1;
        if (ready_mode == 2) out_ready = ($urandom_range(0, 9) < 6);
        else out_ready = (ready_mode == 0);
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [N-1:0] d, input logic last);
        int n;
        logic taken;
        n = 0;
        taken = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!taken && n < 200) begin
            @(negedge clk);
            taken = in_ready;
            cycle();
            n++;
        end
        in_valid = 1'b0;
        if (!taken) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        ready_mode = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            cycle();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        frame_total = 0;
        exp_q.delete();
        hold_prev = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_fire", out_fire, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int beats;
        int gap;
        logic [N-1:0] d;

        #2;
        apply_reset();
        cycle();

`ifdef POPCOUNT_APPROX_EN
        // Approximate count: each full group of 4 is capped at 3, bit 20 exact
        thresh = 8'd0;
        send_beat({N{1'b1}}, 1'b1);
        cycle();
        check("apx_ones", out_count, 16);
        send_beat(21'h00000F, 1'b1);
        cycle();
        check("apx_group", out_count, 3);
        send_beat(21'h100000, 1'b1);
        cycle();
        check("apx_tail", out_count, 1);
        drain();
`else
        // Single all-ones beat. The result appears two edges after the beat
        // is presented.
        thresh = 8'd21;
        send_beat({N{1'b1}}, 1'b1);
        check("lat_early", out_valid, 0);
        cycle();
        check("lat_valid", out_valid, 1);
        check("t1_count", out_count, 21);
        check("t1_fire", out_fire, 1);
        check("t1_sat", out_sat, 0);
        drain();

        // 5+0+7 = 12 < 13, then a back-to-back single beat of 13
        thresh = 8'd13;
        send_beat(rand_bits(5), 1'b0);
        send_beat(rand_bits(0), 1'b0);
        send_beat(rand_bits(7), 1'b1);
        send_beat(rand_bits(13), 1'b1);
        check("t2_count_a", out_count, 12);
        check("t2_fire_a", out_fire, 0);
        cycle();
        check("t2_count_b", out_count, 13);
        check("t2_fire_b", out_fire, 1);
        drain();

        // 13 x 21 = 273 saturates to 255. The next frame starts clean.
        thresh = 8'd100;
        for (int i = 0; i < 13; i++) send_beat({N{1'b1}}, (i == 12));
        send_beat(rand_bits(4), 1'b1);
        check("t3_count", out_count, 255);
        check("t3_sat", out_sat, 1);
        cycle();
        check("t3_count_next", out_count, 4);
        check("t3_sat_next", out_sat, 0);
        drain();
`endif

        // Result held while beats keep arriving: the input must back-pressure
        ready_mode = 1;
        cycle();
        cycle();
        in_valid = 1'b1;
        in_data  = rand_bits(9);
        in_last  = 1'b1;
        repeat (6) cycle();
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        ready_mode = 0;
        repeat (4) cycle();
        in_valid = 1'b0;
        drain();

        // Reset mid-frame discards the partial frame
        thresh = 8'd2;
        send_beat(rand_bits(10), 1'b0);
        send_beat(rand_bits(10), 1'b0);
        #2;
        apply_reset();
        send_beat(rand_bits(3), 1'b1);
        cycle();
`ifndef POPCOUNT_APPROX_EN
        check("rst_next_count", out_count, 3);
`endif
        check("rst_next_valid", out_valid, 1);
        drain();

        // Randomized phases with random back-pressure
        for (int p = 0; p < 8; p++) begin
            thresh = 8'($urandom_range(0, 120));
            ready_mode = 2;
            for (int f = 0; f < 12; f++) begin
                beats = (p % 4 == 3) ? $urandom_range(10, 16) : $urandom_range(1, 6);
                for (int b = 0; b < beats; b++) begin
                    d = N'($urandom);
                    if ($urandom_range(0, 3) == 0) d = {N{1'b1}};
                    send_beat(d, (b == beats - 1));
                    gap = $urandom_range(0, 2);
                    repeat (gap) cycle();
                end
            end
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
